// File: rtl/zjh_scan_disp.sv
// ============================================================================
// Module   : zjh_scan_disp
// Brief    : Four-digit multiplexed seven-segment driver with leading-zero blank
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zjh_scan_disp #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          LZB      = 1'b1
) (
  input  logic        Clk,
  input  logic        MR,
  input  logic        Load,
  input  logic [15:0] D,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        Y4,
  output logic        Y3,
  output logic        Y2,
  output logic        Y1,
  output logic        Frame,
  output logic        Err
);

  localparam logic [7:0] c_TC = 8'(SCAN_DIV - 1);

  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic [7:0]  pre_q, pre_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  y_q, y_d;
  logic        frame_q, frame_d;

  logic [3:0]  blank_k;
  logic [3:0]  digit;

  // {a,b,c,d,e,f,g}; non-BCD codes render blank
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic logic has_bad_nibble(input logic [15:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) ||
           (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
  endfunction

  // Digit k blanks when it and every higher digit are zero; digit0 never blanks
  assign blank_k[0] = 1'b0;
  generate
    for (genvar k = 1; k < 4; k++) begin : g_blank
      assign blank_k[k] = LZB && (data_q[15:4*k] == '0);
    end
  endgenerate

  assign digit = data_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    pre_d   = (pre_q == c_TC) ? 8'd0 : pre_q + 8'd1;
    idx_d   = (pre_q == c_TC) ? idx_q + 2'd1 : idx_q;
    data_d  = Load ? D : data_q;
    err_d   = Load ? has_bad_nibble(D) : err_q;
    y_d     = 4'b0001 << idx_q;
    seg_d   = blank_k[idx_q] ? 7'b0000000 : decode(digit);
    frame_d = y_q[3] && (idx_q == 2'd0);
  end

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      data_q  <= '0;
      err_q   <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      y_q     <= '0;
      frame_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign {Y4, Y3, Y2, Y1}      = y_q;
  assign Frame                 = frame_q;
  assign Err                   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_zjh_scan_disp.sv
// ============================================================================
// Module   : tb_zjh_scan_disp
// Brief    : Self-checking bench for zjh_scan_disp against a cycle-count model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zjh_scan_disp;

  logic        Clk = 1'b0;
  logic        MR = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] D = 16'h0000;

  logic [12:0] oa, ob, oc;
  int checks = 0;
  int failures = 0;

  // Model state: edges since reset release, register contents before/after latest edge
  int          n_edges = 0;
  logic [15:0] vis_data = 16'h0000;
  logic [15:0] cur_data = 16'h0000;

  always #5 Clk = ~Clk;

  zjh_scan_disp #(.SCAN_DIV(4), .LZB(1'b1)) u_a (
    .Clk(Clk), .MR(MR), .Load(Load), .D(D),
    .a(oa[12]), .b(oa[11]), .c(oa[10]), .d(oa[9]), .e(oa[8]), .f(oa[7]), .g(oa[6]),
    .Y4(oa[5]), .Y3(oa[4]), .Y2(oa[3]), .Y1(oa[2]), .Frame(oa[1]), .Err(oa[0]));

  zjh_scan_disp #(.SCAN_DIV(4), .LZB(1'b0)) u_b (
    .Clk(Clk), .MR(MR), .Load(Load), .D(D),
    .a(ob[12]), .b(ob[11]), .c(ob[10]), .d(ob[9]), .e(ob[8]), .f(ob[7]), .g(ob[6]),
    .Y4(ob[5]), .Y3(ob[4]), .Y2(ob[3]), .Y1(ob[2]), .Frame(ob[1]), .Err(ob[0]));

  zjh_scan_disp #(.SCAN_DIV(1), .LZB(1'b1)) u_c (
    .Clk(Clk), .MR(MR), .Load(Load), .D(D),
    .a(oc[12]), .b(oc[11]), .c(oc[10]), .d(oc[9]), .e(oc[8]), .f(oc[7]), .g(oc[6]),
    .Y4(oc[5]), .Y3(oc[4]), .Y2(oc[3]), .Y1(oc[2]), .Frame(oc[1]), .Err(oc[0]));

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected {segs, Y4..Y1, Frame, Err} after n_edges clock edges out of reset
  function automatic logic [12:0] exp_out(input int sd, input bit lzb);
    int idx;
    logic [3:0] dig;
    logic [6:0] s;
    logic [3:0] y;
    bit fr, er, blank;
    if (n_edges == 0) return 13'd0;
    idx   = ((n_edges - 1) / sd) % 4;
    dig   = vis_data[idx*4 +: 4];
    blank = lzb && (idx > 0) && ((vis_data >> (4 * idx)) == 16'd0);
    s     = blank ? 7'd0 : seg_of(dig);
    y     = 4'(1 << idx);
    fr    = (n_edges > 1) && (((n_edges - 1) % (4 * sd)) == 0);
    er    = 1'b0;
    for (int k = 0; k < 4; k++)
      if (cur_data[k*4 +: 4] > 4'd9) er = 1'b1;
    return {s, y, fr, er};
  endfunction

  task automatic tick(input bit ld, input logic [15:0] dv);
    Load = ld;
    D    = dv;
    @(posedge Clk);
    vis_data = cur_data;
    if (ld) cur_data = dv;
    n_edges++;
    #1;
    Load = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[k*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic test_reset();
    #3;
    if ({oa, ob, oc} !== 39'd0) begin
      failures++;
      $display("FAIL reset_hold_1 actual=%h/%h/%h required=0", oa, ob, oc);
    end
    checks++;
    #10;
    if ({oa, ob, oc} !== 39'd0) begin
      failures++;
      $display("FAIL reset_hold_2 actual=%h/%h/%h required=0", oa, ob, oc);
    end
    checks++;
    #9;
    MR = 1'b1;
    n_edges = 0; vis_data = 0; cur_data = 0;
    tick(1'b0, 16'h0000);
    if (oa !== {7'b1111110, 4'b0001, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL first_edge actual=%b required=%b", oa, {7'b1111110, 4'b0001, 2'b00});
    end
    checks++;
  endtask

  task automatic test_scan_zero();
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 16'h0000);
      if (oa !== exp_out(4, 1'b1)) begin
        failures++;
        $display("FAIL scan_zero_a n=%0d actual=%b required=%b", n_edges, oa, exp_out(4, 1'b1));
      end
      if (ob !== exp_out(4, 1'b0)) begin
        failures++;
        $display("FAIL scan_zero_b n=%0d actual=%b required=%b", n_edges, ob, exp_out(4, 1'b0));
      end
      if (oc !== exp_out(1, 1'b1)) begin
        failures++;
        $display("FAIL scan_zero_c n=%0d actual=%b required=%b", n_edges, oc, exp_out(1, 1'b1));
      end
      checks += 3;
    end
  endtask

  task automatic test_load_values();
    logic [15:0] vals [5] = '{16'h1234, 16'h0070, 16'h00A5, 16'h0005, 16'h0000};
    for (int v = 0; v < 5; v++) begin
      tick(1'b1, vals[v]);
      for (int i = 0; i < 20; i++) begin
        tick(1'b0, 16'h0000);
        if (oa !== exp_out(4, 1'b1)) begin
          failures++;
          $display("FAIL load_a D=%h n=%0d actual=%b required=%b", vals[v], n_edges, oa, exp_out(4, 1'b1));
        end
        if (ob !== exp_out(4, 1'b0)) begin
          failures++;
          $display("FAIL load_b D=%h n=%0d actual=%b required=%b", vals[v], n_edges, ob, exp_out(4, 1'b0));
        end
        if (oc !== exp_out(1, 1'b1)) begin
          failures++;
          $display("FAIL load_c D=%h n=%0d actual=%b required=%b", vals[v], n_edges, oc, exp_out(1, 1'b1));
        end
        checks += 3;
      end
    end
  endtask

  task automatic test_load_on_wrap();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 8 && ((n_edges + 1) % 4) != 0; i++) tick(1'b0, 16'h0000);
      tick(1'b1, rand_bcd());
      for (int i = 0; i < 8; i++) begin
        tick(1'b0, 16'h0000);
        if (oa !== exp_out(4, 1'b1)) begin
          failures++;
          $display("FAIL wrap_load_a n=%0d actual=%b required=%b", n_edges, oa, exp_out(4, 1'b1));
        end
        if (ob !== exp_out(4, 1'b0)) begin
          failures++;
          $display("FAIL wrap_load_b n=%0d actual=%b required=%b", n_edges, ob, exp_out(4, 1'b0));
        end
        checks += 2;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] dv;
    bit ld;
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 2))
        0:       dv = 16'($urandom);
        1:       dv = rand_bcd();
        default: dv = rand_bcd() & 16'h00FF;
      endcase
      tick(ld, dv);
      if (oa !== exp_out(4, 1'b1)) begin
        failures++;
        $display("FAIL random_a n=%0d actual=%b required=%b", n_edges, oa, exp_out(4, 1'b1));
      end
      if (ob !== exp_out(4, 1'b0)) begin
        failures++;
        $display("FAIL random_b n=%0d actual=%b required=%b", n_edges, ob, exp_out(4, 1'b0));
      end
      if (oc !== exp_out(1, 1'b1)) begin
        failures++;
        $display("FAIL random_c n=%0d actual=%b required=%b", n_edges, oc, exp_out(1, 1'b1));
      end
      checks += 3;
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    tick(1'b1, 16'h9A87);
    for (int i = 0; i < 40 && !found; i++) begin
      if (oa[5:2] == 4'b0100) found = 1'b1;
      else tick(1'b0, 16'h0000);
    end
    if (!found) begin
      failures++;
      $display("FAIL async_wait_y3 actual=%b required=0100", oa[5:2]);
    end
    checks++;
    #2;
    MR = 1'b0;
    #1;
    if ({oa, ob, oc} !== 39'd0) begin
      failures++;
      $display("FAIL async_reset actual=%h/%h/%h required=0", oa, ob, oc);
    end
    checks++;
    n_edges = 0; vis_data = 0; cur_data = 0;
    #10;
    MR = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 16'h0000);
      if (oa !== exp_out(4, 1'b1)) begin
        failures++;
        $display("FAIL after_reset_a n=%0d actual=%b required=%b", n_edges, oa, exp_out(4, 1'b1));
      end
      if (oc !== exp_out(1, 1'b1)) begin
        failures++;
        $display("FAIL after_reset_c n=%0d actual=%b required=%b", n_edges, oc, exp_out(1, 1'b1));
      end
      checks += 2;
    end
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_load_values();
    test_load_on_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
